a25_scan_ctrl: RTL and testbench

//  On-chip scan test controller; drives the scan ports of a25_core (scan_in*, scan_enable, test_mode).

---
 rtl/a25_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_a25_scan_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a25_scan_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// a25_scan_ctrl
// On-chip scan test controller for a25_core. Consumes a stream of pattern
// beats (one load, expected and mask bit per chain). It loads each pattern,
// runs the capture clocks, and unloads the previous response while loading
// the next pattern. Masked mismatches are counted.
//
// Ports
//   clk, reset        core clock, asynchronous active-low reset
//   start             1-cycle pulse, begins a run when idle
//   shift_len         shift cycles per load/unload (sampled at start)
//   num_patterns      patterns per run (sampled at start)
//   capture_cyc       capture clocks per pattern, 1..3 (0 behaves as 1)
//   pat_valid/ready   beat handshake
//   pat_in/exp/mask   load, expected and compare-enable bit per chain
//   scan_in/scan_out  scan data to/from the core chains
//   scan_enable       1 = shift, 0 = capture
//   test_mode         held 1 for the whole run
//   scan_clk_en       core clock enable, 0 freezes the chains
//   busy, done        run in progress / end-of-run pulse
//   fail_count        saturating count of masked mismatching bits
//   first_fail        {pattern index, shift index} of the first mismatch
// ---------------------------------------------------------------------------
module a25_scan_ctrl #(
   parameter int NUM_CHAINS = 5,
   parameter int LEN_W      = 10,
   parameter int PAT_W      = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [LEN_W-1:0]       shift_len,
   input  logic [PAT_W-1:0]       num_patterns,
   input  logic [1:0]             capture_cyc,
   input  logic                   pat_valid,
   output logic                   pat_ready,
   input  logic [NUM_CHAINS-1:0]  pat_in,
   input  logic [NUM_CHAINS-1:0]  pat_exp,
   input  logic [NUM_CHAINS-1:0]  pat_mask,
   output logic [NUM_CHAINS-1:0]  scan_in,
   input  logic [NUM_CHAINS-1:0]  scan_out,
   output logic                   scan_enable,
   output logic                   test_mode,
   output logic                   scan_clk_en,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            fail_count,
   output logic [PAT_W+LEN_W-1:0] first_fail
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CAPTURE,
      S_UNLOAD,
      S_FINISH
   } state_t;

   state_t state_reg, state_next;

   logic [LEN_W-1:0]       len_reg;
   logic [PAT_W-1:0]       npat_reg;
   logic [LEN_W-1:0]       beat_cnt_reg;
   logic [LEN_W-1:0]       shift_idx_reg;
   logic [PAT_W-1:0]       pat_idx_reg;
   logic [1:0]             cap_cnt_reg;
   logic                   shift_act_reg;
   logic [NUM_CHAINS-1:0]  scan_in_reg;
   logic [NUM_CHAINS-1:0]  exp_reg;
   logic [NUM_CHAINS-1:0]  mask_reg;
   logic                   busy_reg;
   logic                   test_mode_reg;
   logic                   done_reg;
   logic [15:0]            fail_count_reg;
   logic [PAT_W+LEN_W-1:0] first_fail_reg;

   logic                   shifting;
   logic                   accept;
   logic                   last_beat_done;
   logic                   cap_last;
   logic [1:0]             cap_total;
   logic                   compare_en;
   logic [NUM_CHAINS-1:0]  mism;
   logic [7:0]             mism_pop;
   logic [16:0]            fail_sum;
   logic [15:0]            fail_count_next;

   // ------------------------------------------------------------------
   // Per-chain mismatch of the bit leaving the chain this cycle
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_mism
         assign mism[gi] = (scan_out[gi] ^ exp_reg[gi]) & mask_reg[gi];
      end
   endgenerate

   always_comb begin
      mism_pop = 8'd0;
      for (int i = 0; i < NUM_CHAINS; i++) begin
         mism_pop = mism_pop + 8'(mism[i]);
      end
      fail_sum        = {1'b0, fail_count_reg} + 17'(mism_pop);
      fail_count_next = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
   end

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   assign shifting  = (state_reg == S_SHIFT) || (state_reg == S_UNLOAD);
   // Once shift_len beats are taken the handshake closes; the final
   // shift cycle still runs before leaving the state.
   assign pat_ready = shifting && (beat_cnt_reg != len_reg);
   assign accept    = pat_valid && pat_ready;
   assign last_beat_done = shift_act_reg && (beat_cnt_reg == len_reg);
   assign cap_total = (capture_cyc == 2'd0) ? 2'd1 : capture_cyc;
   assign cap_last  = (cap_cnt_reg >= cap_total - 2'd1);
   // Load 0 shifts out whatever the chains held before the run.
   assign compare_en = shifting && shift_act_reg && (pat_idx_reg != '0);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      scan_enable = 1'b0;
      scan_clk_en = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               if ((shift_len == '0) || (num_patterns == '0)) begin
                  state_next = S_FINISH;
               end else begin
                  state_next = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            scan_enable = 1'b1;
            scan_clk_en = shift_act_reg;
            if (last_beat_done) begin
               state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            scan_clk_en = 1'b1;
            if (cap_last) begin
               if (pat_idx_reg == npat_reg - PAT_W'(1)) begin
                  state_next = S_UNLOAD;
               end else begin
                  state_next = S_SHIFT;
               end
            end
         end
         S_UNLOAD: begin
            scan_enable = 1'b1;
            scan_clk_en = shift_act_reg;
            if (last_beat_done) begin
               state_next = S_FINISH;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_reg        <= '0;
         npat_reg       <= '0;
         beat_cnt_reg   <= '0;
         shift_idx_reg  <= '0;
         pat_idx_reg    <= '0;
         cap_cnt_reg    <= '0;
         shift_act_reg  <= 1'b0;
         scan_in_reg    <= '0;
         exp_reg        <= '0;
         mask_reg       <= '0;
         busy_reg       <= 1'b0;
         test_mode_reg  <= 1'b0;
         done_reg       <= 1'b0;
         fail_count_reg <= '0;
         first_fail_reg <= '1;
      end else begin
         done_reg      <= (state_reg == S_FINISH);
         shift_act_reg <= accept;

         if ((state_reg == S_IDLE) && start) begin
            len_reg        <= shift_len;
            npat_reg       <= num_patterns;
            beat_cnt_reg   <= '0;
            pat_idx_reg    <= '0;
            cap_cnt_reg    <= '0;
            fail_count_reg <= '0;
            first_fail_reg <= '1;
            busy_reg       <= 1'b1;
            test_mode_reg  <= 1'b1;
         end

         if (state_reg == S_FINISH) begin
            busy_reg      <= 1'b0;
            test_mode_reg <= 1'b0;
         end

         if (accept) begin
            scan_in_reg   <= pat_in;
            exp_reg       <= pat_exp;
            mask_reg      <= pat_mask;
            shift_idx_reg <= beat_cnt_reg;
            beat_cnt_reg  <= beat_cnt_reg + LEN_W'(1);
         end

         if (state_reg == S_CAPTURE) begin
            if (cap_last) begin
               cap_cnt_reg  <= '0;
               beat_cnt_reg <= '0;
               pat_idx_reg  <= pat_idx_reg + PAT_W'(1);
            end else begin
               cap_cnt_reg  <= cap_cnt_reg + 2'd1;
            end
         end

         // Load k carries the response of pattern k-1.
         if (compare_en) begin
            fail_count_reg <= fail_count_next;
            if ((mism != '0) && (&first_fail_reg)) begin
               first_fail_reg <= {pat_idx_reg - PAT_W'(1), shift_idx_reg};
            end
         end
      end
   end

   assign scan_in    = scan_in_reg;
   assign busy       = busy_reg;
   assign test_mode  = test_mode_reg;
   assign done       = done_reg;
   assign fail_count = fail_count_reg;
   assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_a25_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for a25_scan_ctrl with a 4-bit-per-chain core model.
module tb_a25_scan_ctrl;
   localparam int NC = 5;
   localparam int LW = 10;
   localparam int PW = 12;
   localparam int L  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] shift_len = '0;
   logic [PW-1:0] num_patterns = '0;
   logic [1:0]    capture_cyc = 2'd1;
   logic          pat_valid = 1'b0;
   logic          pat_ready;
   logic [NC-1:0] pat_in = '0;
   logic [NC-1:0] pat_exp = '0;
   logic [NC-1:0] pat_mask = '0;
   logic [NC-1:0] scan_in;
   logic [NC-1:0] scan_out;
   logic          scan_enable, test_mode, scan_clk_en, busy, done;
   logic [15:0]   fail_count;
   logic [PW+LW-1:0] first_fail;

   int errors = 0;
   int checks = 0;

   a25_scan_ctrl #(.NUM_CHAINS(NC), .LEN_W(LW), .PAT_W(PW)) dut (
      .clk(clk), .reset(reset), .start(start), .shift_len(shift_len),
      .num_patterns(num_patterns), .capture_cyc(capture_cyc),
      .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_in(pat_in),
      .pat_exp(pat_exp), .pat_mask(pat_mask), .scan_in(scan_in),
      .scan_out(scan_out), .scan_enable(scan_enable), .test_mode(test_mode),
      .scan_clk_en(scan_clk_en), .busy(busy), .done(done),
      .fail_count(fail_count), .first_fail(first_fail)
   );

   always #5 clk = ~clk;

   // Core model: each chain is L bits, capture leaves contents unchanged,
   // so the response of pattern k equals its load.
   logic [L-1:0] chain [NC];
   initial for (int c = 0; c < NC; c++) chain[c] = '0;
   always @(posedge clk) begin
      if (scan_clk_en && scan_enable) begin
         for (int c = 0; c < NC; c++) chain[c] <= {chain[c][L-2:0], scan_in[c]};
      end
   end
   for (genvar gi = 0; gi < NC; gi++) begin : g_so
      assign scan_out[gi] = chain[gi][L-1];
   end

   // Activity monitor
   int shift_cyc = 0, cap_cyc = 0, done_cnt = 0, viol = 0, se_cnt = 0, stall_cyc = 0;
   logic acc_q = 1'b0;
   always @(posedge clk) acc_q <= pat_valid & pat_ready;
   always @(negedge clk) begin
      if (scan_enable && scan_clk_en)  shift_cyc <= shift_cyc + 1;
      if (!scan_enable && scan_clk_en) cap_cyc   <= cap_cyc + 1;
      if (scan_enable)                 se_cnt    <= se_cnt + 1;
      if (scan_enable && !scan_clk_en) stall_cyc <= stall_cyc + 1;
      if (done)                        done_cnt  <= done_cnt + 1;
      if ((scan_enable && (scan_clk_en != acc_q)) ||
          (!scan_enable && scan_clk_en && pat_ready) ||
          (busy != test_mode))         viol      <= viol + 1;
   end

   int b_shift, b_cap, b_done, b_viol, b_se, b_stall;

   task automatic snap();
      b_shift = shift_cyc; b_cap = cap_cyc; b_done = done_cnt;
      b_viol = viol; b_se = se_cnt; b_stall = stall_cyc;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NC-1:0] data(input int k, input int j);
      int v;
      v = k * 9 + j * 13 + 6 + ((k * j) << 2);
      return v[NC-1:0];
   endfunction

   function automatic logic [31:0] final_chain(input int k);
      logic [31:0] r;
      logic [NC-1:0] d;
      r = '0;
      for (int j = 0; j < L; j++) begin
         d = data(k, j);
         for (int c = 0; c < NC; c++) r[c*L + (L-1-j)] = d[c];
      end
      return r;
   endfunction

   function automatic logic [31:0] chain_packed();
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < NC; c++) r[c*L +: L] = chain[c];
      return r;
   endfunction

   task automatic do_start(input int len, input int np, input int cap);
      shift_len = LW'(len); num_patterns = PW'(np); capture_cyc = 2'(cap);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Drives nbeats beats; (fk,fj) selects a beat whose chain-2 expectation is inverted.
   task automatic drive_beats(input int nbeats, input bit gaps, input bit masks,
                              input int fk, input int fj);
      int i, cyc, k, j;
      bit phase, acc;
      logic [NC-1:0] e;
      i = 0; cyc = 0; phase = 1'b0;
      while (i < nbeats && cyc < 3000) begin
         k = i / L; j = i % L;
         if (gaps && phase) begin
            pat_valid = 1'b0;
         end else begin
            e = (k == 0) ? '1 : data(k-1, j);
            if (k == fk && j == fj) e[2] = ~e[2];
            pat_valid = 1'b1;
            pat_in    = data(k, j);
            pat_exp   = e;
            pat_mask  = masks ? '1 : '0;
         end
         phase = ~phase;
         acc = pat_valid && pat_ready;
         tick();
         cyc++;
         if (acc) i++;
      end
      pat_valid = 1'b0;
      chk("beats_accepted", 32'(i), 32'(nbeats));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_tm", 32'(test_mode), 0);
      chk("rst_se", 32'(scan_enable), 0);
      chk("rst_cke", 32'(scan_clk_en), 0);
      chk("rst_ready", 32'(pat_ready), 0);
      chk("rst_scan_in", 32'(scan_in), 0);
      chk("rst_fcnt", 32'(fail_count), 0);
      chk("rst_ffail", 32'(first_fail), 32'h3FFFFF);
      reset = 1'b1;
      tick();

      // Test 1: masks off, 12 beats, 2 capture windows of 2
      snap();
      do_start(4, 2, 2);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_tm", 32'(test_mode), 1);
      drive_beats(12, 1'b0, 1'b0, -1, -1);
      wait_done();
      $display("t1 shift=%0d cap=%0d fail_count=%0d", shift_cyc-b_shift, cap_cyc-b_cap, fail_count);
      chk("t1_shift", 32'(shift_cyc - b_shift), 12);
      chk("t1_cap", 32'(cap_cyc - b_cap), 4);
      chk("t1_done", 32'(done_cnt - b_done), 1);
      chk("t1_viol", 32'(viol - b_viol), 0);
      chk("t1_fcnt", 32'(fail_count), 0);
      chk("t1_busy_end", 32'(busy), 0);
      chk("t1_tm_end", 32'(test_mode), 0);

      // Test 2: echo core, masks on, capture_cyc=0 behaves as 1
      snap();
      do_start(4, 2, 0);
      drive_beats(12, 1'b0, 1'b1, -1, -1);
      wait_done();
      $display("t2 fail_count=%0d first_fail=%0h", fail_count, first_fail);
      chk("t2_cap", 32'(cap_cyc - b_cap), 2);
      chk("t2_fcnt", 32'(fail_count), 0);
      chk("t2_ffail", 32'(first_fail), 32'h3FFFFF);
      chk("t2_chain", chain_packed(), final_chain(2));

      // Test 3: chain 2 of pattern 1 response, shift index 3
      snap();
      do_start(4, 2, 3);
      drive_beats(12, 1'b0, 1'b1, 2, 3);
      wait_done();
      $display("t3 fail_count=%0d first_fail=%0h", fail_count, first_fail);
      chk("t3_cap", 32'(cap_cyc - b_cap), 6);
      chk("t3_fcnt", 32'(fail_count), 1);
      chk("t3_ffail", 32'(first_fail), 32'h403);

      // Test 4: valid every other cycle
      snap();
      do_start(4, 2, 1);
      drive_beats(12, 1'b1, 1'b1, -1, -1);
      wait_done();
      $display("t4 shift=%0d stalls=%0d fail_count=%0d", shift_cyc-b_shift, stall_cyc-b_stall, fail_count);
      chk("t4_shift", 32'(shift_cyc - b_shift), 12);
      chk("t4_stalls", 32'((stall_cyc - b_stall) > 0), 1);
      chk("t4_viol", 32'(viol - b_viol), 0);
      chk("t4_fcnt", 32'(fail_count), 0);
      chk("t4_chain", chain_packed(), final_chain(2));

      // Test 5: zero shift_len / zero num_patterns
      snap();
      do_start(0, 3, 1);
      chk("t5_done_c1", 32'(done), 0);
      chk("t5_busy_c1", 32'(busy), 1);
      tick();
      chk("t5_done_c2", 32'(done), 1);
      chk("t5_busy_c2", 32'(busy), 0);
      tick();
      chk("t5_done_pulse", 32'(done), 0);
      do_start(4, 0, 1);
      tick();
      chk("t5_np0_done", 32'(done), 1);
      tick();
      chk("t5_se_never", 32'(se_cnt - b_se), 0);
      $display("t5 zero-length runs done_pulses=%0d", done_cnt - b_done);

      // Start while busy is ignored
      snap();
      do_start(4, 1, 1);
      tick();
      do_start(0, 0, 1);
      tick(); tick();
      chk("t5b_busy", 32'(busy), 1);
      chk("t5b_no_done", 32'(done_cnt - b_done), 0);
      drive_beats(8, 1'b0, 1'b1, -1, -1);
      wait_done();
      $display("t5b shift=%0d fail_count=%0d", shift_cyc-b_shift, fail_count);
      chk("t5b_shift", 32'(shift_cyc - b_shift), 8);
      chk("t5b_fcnt", 32'(fail_count), 0);
      chk("t5b_done", 32'(done_cnt - b_done), 1);

      // Test 6: reset during capture
      snap();
      do_start(4, 2, 3);
      drive_beats(4, 1'b0, 1'b1, -1, -1);
      begin
         int n;
         n = 0;
         while (!(!scan_enable && scan_clk_en) && n < 50) begin
            tick();
            n++;
         end
      end
      chk("t6_in_capture", 32'(!scan_enable && scan_clk_en), 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_se", 32'(scan_enable), 0);
      chk("t6_cke", 32'(scan_clk_en), 0);
      chk("t6_tm", 32'(test_mode), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_ready", 32'(pat_ready), 0);
      tick(); tick(); tick();
      reset = 1'b1;
      tick(); tick(); tick();
      chk("t6_no_done", 32'(done_cnt - b_done), 0);
      $display("t6 reset during capture busy=%0d", busy);
      snap();
      do_start(4, 2, 2);
      drive_beats(12, 1'b0, 1'b1, -1, -1);
      wait_done();
      $display("t6b fail_count=%0d first_fail=%0h", fail_count, first_fail);
      chk("t6b_fcnt", 32'(fail_count), 0);
      chk("t6b_ffail", 32'(first_fail), 32'h3FFFFF);
      chk("t6b_done", 32'(done_cnt - b_done), 1);
      chk("t6b_viol", 32'(viol - b_viol), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
